// File: rtl/life_step_if.sv
// life_step_if: seed/step controls in, board and status out.
// Sized by W and H to match the engine instance.
interface life_step_if #(
   parameter int W = 32,
   parameter int H = 24
);
   localparam int L  = W * H;
   localparam int AW = $clog2(L + 1);

   logic [L-1:0]  board_in;
   logic          load;
   logic          step;
   logic [L-1:0]  board_out;
   logic          busy;
   logic          done;
   logic [15:0]   gen_count;
   logic [AW-1:0] alive_count;
   logic          stable;

   modport master (
      output board_in, load, step,
      input  board_out, busy, done,
      input  gen_count, alive_count, stable
   );

   modport slave (
      input  board_in, load, step,
      output board_out, busy, done,
      output gen_count, alive_count, stable
   );
endinterface

// File: rtl/life_step.sv
// life_step: Game of Life (B3/S23) next-generation engine, one row per cycle.
// Define LIFE_TORUS_EN for toroidal wrap; default has dead borders.
module life_step #(
   parameter int W = 32,
   parameter int H = 24
) (
   input  logic      clk,
   input  logic      rst_n,
   life_step_if.slave bus
);
   localparam int L  = W * H;
   localparam int AW = $clog2(L + 1);
   localparam int RW = $clog2(H);
   localparam int PW = $clog2(W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPUTE,
      S_COMMIT
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [RW-1:0] row;
   logic [L-1:0]  board;
   logic [L-1:0]  shadow;
   logic [15:0]   gen;
   logic [AW-1:0] alive;
   logic [AW-1:0] acc;
   logic          diff;
   logic          stab;
   logic          busy_q;
   logic          done_q;

   logic [W-1:0]  up;
   logic [W-1:0]  cur;
   logic [W-1:0]  dn;
   logic [W+1:0]  eu;
   logic [W+1:0]  ec;
   logic [W+1:0]  ed;
   logic [W-1:0]  nxt;
   logic [3:0]    n;
   logic [PW-1:0] row_pop;
   logic          row_diff;
   logic [AW-1:0] pop_in;
   logic          last_row;

   assign last_row = (row == RW'(H - 1));

   // Fetch the three source rows and extend them with border/wrap columns
   always_comb begin
      cur = board[int'(row)*W +: W];
      up  = '0;
      dn  = '0;
      if (row == '0) begin
`ifdef LIFE_TORUS_EN
         up = board[(H-1)*W +: W];
`endif
      end else begin
         up = board[(int'(row)-1)*W +: W];
      end
      if (last_row) begin
`ifdef LIFE_TORUS_EN
         dn = board[W-1:0];
`endif
      end else begin
         dn = board[(int'(row)+1)*W +: W];
      end
`ifdef LIFE_TORUS_EN
      eu = {up[0], up, up[W-1]};
      ec = {cur[0], cur, cur[W-1]};
      ed = {dn[0], dn, dn[W-1]};
`else
      eu = {1'b0, up, 1'b0};
      ec = {1'b0, cur, 1'b0};
      ed = {1'b0, dn, 1'b0};
`endif
   end

   // Apply B3/S23 to every cell of the current row
   always_comb begin
      nxt     = '0;
      n       = '0;
      row_pop = '0;
      for (int x = 0; x < W; x++) begin
         n = 4'(eu[x]) + 4'(eu[x+1]) + 4'(eu[x+2])
           + 4'(ec[x]) + 4'(ec[x+2])
           + 4'(ed[x]) + 4'(ed[x+1]) + 4'(ed[x+2]);
         nxt[x]  = (n == 4'd3) | (ec[x+1] & (n == 4'd2));
         row_pop = row_pop + PW'(nxt[x]);
      end
      row_diff = (nxt != cur);
   end

   // Live-cell count of the seed board, taken on load
   always_comb begin
      pop_in = '0;
      for (int i = 0; i < L; i++) begin
         pop_in = pop_in + AW'(bus.board_in[i]);
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next state: load beats step, everything ignored while busy
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (bus.step && !bus.load) state_nx = S_COMPUTE;
         end
         S_COMPUTE: begin
            if (last_row) state_nx = S_COMMIT;
         end
         S_COMMIT: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Datapath: load, per-row shadow fill with running sums, atomic commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row    <= '0;
         board  <= '0;
         shadow <= '0;
         gen    <= '0;
         alive  <= '0;
         acc    <= '0;
         diff   <= 1'b0;
         stab   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         busy_q <= (state_nx != S_IDLE);
         unique case (state)
            S_IDLE: begin
               if (bus.load) begin
                  board <= bus.board_in;
                  gen   <= '0;
                  alive <= pop_in;
                  stab  <= 1'b0;
               end else if (bus.step) begin
                  row <= '0;
               end
            end
            S_COMPUTE: begin
               shadow[int'(row)*W +: W] <= nxt;
               if (row == '0) begin
                  acc  <= AW'(row_pop);
                  diff <= row_diff;
               end else begin
                  acc  <= acc + AW'(row_pop);
                  diff <= diff | row_diff;
               end
               row <= last_row ? '0 : row + 1'b1;
            end
            S_COMMIT: begin
               board  <= shadow;
               gen    <= gen + 16'd1;
               alive  <= acc;
               stab   <= ~diff;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.board_out   = board;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.gen_count   = gen;
   assign bus.alive_count = alive;
   assign bus.stable      = stab;
endmodule

// File: tb/tb_life_step.sv
// tb_life_step: directed Game of Life patterns against life_step.
// Expected boards and counts are hand-derived constants.
module tb_life_step;
   localparam int W  = 32;
   localparam int H  = 24;
   localparam int L  = W * H;
   localparam int CW = 800;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   int   cyc;

   logic [L-1:0] b_h;
   logic [L-1:0] b_v;
   logic [L-1:0] b_blk;
   logic [L-1:0] b_e0;
   logic [L-1:0] b_e1;

   life_step_if #(.W(W), .H(H)) bus ();

   life_step #(.W(W), .H(H)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [L-1:0] setc(
      input logic [L-1:0] b,
      input int x,
      input int y
   );
      logic [L-1:0] r;
      r = b;
      r[y*W + x] = 1'b1;
      return r;
   endfunction

   task automatic chk(
      input string        tag,
      input logic [CW-1:0] obs,
      input logic [CW-1:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [L-1:0] b);
      bus.board_in = b;
      bus.load     = 1'b1;
      tick();
      bus.load     = 1'b0;
   endtask

   task automatic wait_done(output int c);
      c = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         c++;
         if (bus.done) break;
      end
   endtask

   task automatic do_step(input string tag);
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      chk({tag, "_busy"}, CW'(bus.busy), CW'(1));
      wait_done(cyc);
      chk({tag, "_lat"}, CW'(cyc), CW'(25));
      chk({tag, "_idle"}, CW'(bus.busy), CW'(0));
   endtask

   initial begin
      errors = 0;
      checks = 0;
      b_h   = setc(setc(setc('0, 10, 5), 11, 5), 12, 5);
      b_v   = setc(setc(setc('0, 11, 4), 11, 5), 11, 6);
      b_blk = setc(setc(setc(setc('0, 3, 3), 4, 3), 3, 4), 4, 4);
`ifdef LIFE_TORUS_EN
      b_e0  = setc(setc(setc('0, 31, 0), 0, 0), 1, 0);
      b_e1  = setc(setc(setc('0, 0, 23), 0, 0), 0, 1);
`else
      b_e0  = setc(setc(setc('0, 0, 0), 1, 0), 2, 0);
      b_e1  = setc(setc('0, 1, 0), 1, 1);
`endif

      rst_n        = 1'b0;
      bus.board_in = '0;
      bus.load     = 1'b0;
      bus.step     = 1'b0;
      #2;
      chk("rst_board", CW'(bus.board_out), CW'(0));
      chk("rst_gen", CW'(bus.gen_count), CW'(0));
      chk("rst_alive", CW'(bus.alive_count), CW'(0));
      chk("rst_flags", CW'({bus.busy, bus.done, bus.stable}), CW'(0));
      tick();
      rst_n = 1'b1;
      tick();

      // Blinker oscillates with period 2
      do_load(b_h);
      chk("bl_load_alive", CW'(bus.alive_count), CW'(3));
      do_step("bl1");
      chk("bl1_board", CW'(bus.board_out), CW'(b_v));
      chk("bl1_alive", CW'(bus.alive_count), CW'(3));
      chk("bl1_gen", CW'(bus.gen_count), CW'(1));
      chk("bl1_stable", CW'(bus.stable), CW'(0));
      tick();
      chk("bl1_done_pulse", CW'(bus.done), CW'(0));
      do_step("bl2");
      chk("bl2_board", CW'(bus.board_out), CW'(b_h));
      chk("bl2_gen", CW'(bus.gen_count), CW'(2));

      // Block is a still life
      do_load(b_blk);
      chk("blk_gen0", CW'(bus.gen_count), CW'(0));
      chk("blk_alive0", CW'(bus.alive_count), CW'(4));
      do_step("blk");
      chk("blk_board", CW'(bus.board_out), CW'(b_blk));
      chk("blk_alive", CW'(bus.alive_count), CW'(4));
      chk("blk_stable", CW'(bus.stable), CW'(1));

      // Edge behaviour (dead border or torus)
      do_load(b_e0);
      do_step("edge");
      chk("edge_board", CW'(bus.board_out), CW'(b_e1));
`ifdef LIFE_TORUS_EN
      chk("edge_alive", CW'(bus.alive_count), CW'(3));
`else
      chk("edge_alive", CW'(bus.alive_count), CW'(2));
`endif

      // Load and step while busy are dropped
      do_load(b_h);
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      repeat (4) tick();
      bus.board_in = b_blk;
      bus.load     = 1'b1;
      bus.step     = 1'b1;
      tick();
      bus.load     = 1'b0;
      bus.step     = 1'b0;
      chk("lock_frozen", CW'(bus.board_out), CW'(b_h));
      chk("lock_gen_mid", CW'(bus.gen_count), CW'(0));
      wait_done(cyc);
      chk("lock_done", CW'(bus.done), CW'(1));
      chk("lock_board", CW'(bus.board_out), CW'(b_v));
      chk("lock_gen", CW'(bus.gen_count), CW'(1));
      repeat (3) tick();
      chk("lock_noq", CW'(bus.busy), CW'(0));

      // Simultaneous load and step: load wins
      bus.board_in = b_blk;
      bus.load     = 1'b1;
      bus.step     = 1'b1;
      tick();
      bus.load     = 1'b0;
      bus.step     = 1'b0;
      chk("ls_board", CW'(bus.board_out), CW'(b_blk));
      chk("ls_gen", CW'(bus.gen_count), CW'(0));
      chk("ls_busy", CW'(bus.busy), CW'(0));
      tick();
      chk("ls_busy2", CW'(bus.busy), CW'(0));

      // Reset during compute aborts cleanly
      do_step("pre");
      do_load(b_h);
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      chk("mrst_board", CW'(bus.board_out), CW'(0));
      chk("mrst_gen", CW'(bus.gen_count), CW'(0));
      chk("mrst_alive", CW'(bus.alive_count), CW'(0));
      chk("mrst_flags", CW'({bus.busy, bus.done, bus.stable}), CW'(0));
      tick();
      rst_n = 1'b1;
      tick();
      do_step("zero");
      chk("zero_board", CW'(bus.board_out), CW'(0));
      chk("zero_alive", CW'(bus.alive_count), CW'(0));
      chk("zero_stable", CW'(bus.stable), CW'(1));
      chk("zero_gen", CW'(bus.gen_count), CW'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/life_step.md
Name: life_step

Overview:
- Next-generation engine downstream of the random board generator.
- Takes the flat L-bit board produced upstream and holds it as the current generation.
- On each step request, computes the next Game of Life generation one row per cycle (B3/S23 rules) into a shadow buffer, then commits it atomically.
- Publishes the board, generation count, live-cell count and a stable flag to the display/control logic.

Parameters:
- W, 32, board width in cells.
- H, 24, board height in rows.
- L, W*H, total cells. Cell (x,y) sits at bit index y*W + x.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- board_in  input  L  seed board from the generator, sampled on load.
- load  input  1  single-cycle pulse: copy board_in into the current generation.
- step  input  1  single-cycle pulse: compute one generation.
- board_out  output  L  current generation (registered).
- busy  output  1  high while a step is in progress.
- done  output  1  one-cycle pulse after a commit.
- gen_count  output  16  generations committed since the last load or reset.
- alive_count  output  clog2(L+1)  live cells in board_out (10 bits at the defaults).
- stable  output  1  the last commit produced a board identical to its predecessor.

Behaviour:
- Reset (async, rst_n=0):
  - board_out, shadow buffer, gen_count, alive_count = 0.
  - busy, done, stable = 0; row counter = 0; state = IDLE.
  - Reset asserted mid-step aborts the step; no partial commit is visible.
- States:
  - IDLE → COMPUTE on step.
  - COMPUTE → COMMIT after row H-1.
  - COMMIT → IDLE unconditionally.
- IDLE:
  - load=1: board_out <= board_in; gen_count <= 0; alive_count <= popcount(board_in) (may take a one-cycle pipelined popcount; alive_count is valid by the edge after load); stable <= 0.
  - load and step together: load wins, step is dropped.
  - step=1 (load=0): row <= 0, busy <= 1, enter COMPUTE.
- COMPUTE:
  - Each cycle evaluates all W cells of row `row` from rows row-1, row, row+1 of board_out; results go to the shadow row.
  - A per-row popcount accumulates into a running alive sum; a per-row inequality check ORs into a diff flag.
  - row increments; leaving row H-1 enters COMMIT.
  - Neighbour count is 0..8 (4 bits). next = (n==3) | (cur & n==2).
- COMMIT (one cycle):
  - board_out <= shadow; gen_count <= gen_count+1 (wraps 0xFFFF→0).
  - alive_count <= accumulated sum; stable <= ~diff.
  - busy <= 0; done <= 1 in the following cycle only.
- Latency: step sampled at edge t → busy high after t; rows written on edges t+1..t+H; commit on edge t+H+1; done high for the cycle after t+H+1. Total H+1 cycles per generation.
- load or step while busy is ignored, with no queueing.
- board_out never changes during COMPUTE.
- An empty board stepped stays empty: alive_count 0, stable 1.

Optional Feature:
- Macro LIFE_TORUS_EN.
- Defined: the board wraps toroidally.
  - Row -1 ≡ H-1, row H ≡ 0.
  - Column -1 ≡ W-1, column W ≡ 0.
- Undefined: out-of-range neighbours read as dead; all edges are fixed dead borders.
- Timing and ports are identical in both builds.

Test Plan:
- Blinker: load cells (10,5),(11,5),(12,5), then step → done 25 cycles after step; board = (11,4),(11,5),(11,6); alive_count 3; gen_count 1; stable 0. A second step restores the original board; gen_count 2.
- Still life: load block (3,3),(4,3),(3,4),(4,4), then step → board unchanged; alive_count 4; stable 1.
- Edge handling:
  - With LIFE_TORUS_EN: load (31,0),(0,0),(1,0), then step → (0,23),(0,0),(0,1); alive 3.
  - Without it: load (0,0),(1,0),(2,0), then step → (1,0),(1,1); alive 2.
- Busy lockout: step, then at cycle 5 pulse load with a different board and a second step → both ignored; result equals the first step's generation; gen_count 1.
- Simultaneous load+step in IDLE → board = board_in, gen_count 0, busy stays 0.
- Reset mid-step: pull rst_n low at cycle 10 of COMPUTE → all outputs 0 immediately; after release, a step on the zero board gives alive 0, stable 1, gen_count 1.
